// File: rtl/dram_arb_pkg.sv
// Shared widths, command encodings and the request record for the DRAM arbiter.
package dram_arb_pkg;

  localparam int unsigned DRAM_ADDR_W = 27;
  localparam int unsigned DRAM_DATA_W = 128;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  typedef struct packed {
    logic                   cmd;
    logic [DRAM_ADDR_W-1:0] addr;
    logic [DRAM_DATA_W-1:0] data;
  } dram_req_t;

endpackage

// File: rtl/dram_arb_tag_fifo.sv
// In-order FIFO of requester ids for reads that are still waiting on their data.
// Depth must be a power of two so the pointers wrap for free.
module dram_arb_tag_fifo #(
  parameter int unsigned IdW   = 1,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [IdW-1:0]           push_id_i,
  input  logic                     pop_i,
  output logic [IdW-1:0]           head_id_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [IdW-1:0]       mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [$clog2(Depth):0] count_q, count_d;
  logic                 do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (32'(count_q) == Depth);
  assign count_o   = count_q;
  assign head_id_o = mem_q[rd_ptr_q];

  // Overflow and underflow are dropped here as a last line of defence.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Id storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM request/response channel between NUM_REQ requesters.
// Requests land in a one-entry output register; read data is steered back by an in-order
// tag FIFO. Optional DRAM_ARB_PERF_EN adds per-requester grant/stall counters.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                                  ui_clk_i,
  input  logic                                  ui_clk_sync_rst_i,
  input  logic [NUM_REQ-1:0]                    req_en_i,
  output logic [NUM_REQ-1:0]                    req_rdy_o,
  input  logic [NUM_REQ-1:0]                    req_cmd_i,
  input  logic [NUM_REQ-1:0][DRAM_ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DRAM_DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                    rsp_en_o,
  output logic [DRAM_DATA_W-1:0]                rsp_data_o,
  output logic                                  dram_req_en_o,
  input  logic                                  dram_req_rdy_i,
  output logic                                  dram_req_cmd_o,
  output logic [DRAM_ADDR_W-1:0]                dram_req_addr_o,
  output logic [DRAM_DATA_W-1:0]                dram_req_data_o,
  input  logic                                  dram_rsp_en_i,
  input  logic [DRAM_DATA_W-1:0]                dram_rsp_data_i,
  output logic                                  err_rsp_unexp_o
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]              perf_grant_o,
  output logic [NUM_REQ-1:0][31:0]              perf_stall_o
`endif
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;

  logic                obuf_valid_q, obuf_valid_d;
  dram_req_t           obuf_q, obuf_d;
  logic [IdW-1:0]      last_q, last_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                grant_found;
  logic [IdW-1:0]      grant_idx;
  logic [IdW-1:0]      rr_cand;
  logic                can_load;
  logic                grant;

  logic                tag_push, tag_pop, tag_empty, tag_full, tag_credit;
  logic [IdW-1:0]      tag_head;
  logic [CntW-1:0]     tag_count;

  // The output register frees up when empty or when it drains this cycle.
  assign can_load   = !obuf_valid_q || dram_req_rdy_i;
  assign tag_credit = 32'(tag_count) < TAG_DEPTH;

  // Writes are always eligible; reads only while a tag slot is free.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_en_i[i] && ((req_cmd_i[i] == CMD_WRITE) || tag_credit);
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_cand = IdW'((32'(last_q) + k) % NUM_REQ);
      if (!grant_found && eligible[rr_cand]) begin
        grant_found = 1'b1;
        grant_idx   = rr_cand;
      end
    end
  end

  assign grant     = can_load && grant_found;
  assign req_rdy_o = grant ? (NUM_REQ'(1) << grant_idx) : '0;

  // Output register, round-robin pointer and sticky error next-state.
  always_comb begin
    obuf_valid_d = obuf_valid_q;
    obuf_d       = obuf_q;
    last_d       = last_q;
    err_d        = err_q | (dram_rsp_en_i && tag_empty);
    if (can_load) begin
      obuf_valid_d = grant_found;
      if (grant_found) begin
        obuf_d = '{cmd:  req_cmd_i[grant_idx],
                   addr: req_addr_i[grant_idx],
                   data: req_data_i[grant_idx]};
        last_d = grant_idx;
      end
    end
  end

  // State registers; synchronous reset shared with the DRAM controller.
  always_ff @(posedge ui_clk_i) begin
    if (ui_clk_sync_rst_i) begin
      obuf_valid_q <= 1'b0;
      obuf_q       <= '0;
      last_q       <= IdW'(NUM_REQ - 1);
      err_q        <= 1'b0;
    end else begin
      obuf_valid_q <= obuf_valid_d;
      obuf_q       <= obuf_d;
      last_q       <= last_d;
      err_q        <= err_d;
    end
  end

  assign dram_req_en_o   = obuf_valid_q;
  assign dram_req_cmd_o  = obuf_q.cmd;
  assign dram_req_addr_o = obuf_q.addr;
  assign dram_req_data_o = obuf_q.data;
  assign err_rsp_unexp_o = err_q;

  // Reads are tagged at grant time, so response order matches issue order.
  assign tag_push = grant && (req_cmd_i[grant_idx] == CMD_READ) && !tag_full;
  assign tag_pop  = dram_rsp_en_i && !tag_empty;

  dram_arb_tag_fifo #(
    .IdW   (IdW),
    .Depth (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i     (ui_clk_i),
    .rst_i     (ui_clk_sync_rst_i),
    .push_i    (tag_push),
    .push_id_i (grant_idx),
    .pop_i     (tag_pop),
    .head_id_o (tag_head),
    .count_o   (tag_count),
    .empty_o   (tag_empty),
    .full_o    (tag_full)
  );

  assign rsp_en_o   = tag_pop ? (NUM_REQ'(1) << tag_head) : '0;
  assign rsp_data_o = dram_rsp_data_i;

`ifdef DRAM_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_grant_q, perf_grant_d;
  logic [NUM_REQ-1:0][31:0] perf_stall_q, perf_stall_d;

  // Saturating per-requester grant and stall counters.
  always_comb begin
    perf_grant_d = perf_grant_q;
    perf_stall_d = perf_stall_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_en_i[i] && req_rdy_o[i] && (perf_grant_q[i] != '1)) begin
        perf_grant_d[i] = perf_grant_q[i] + 32'd1;
      end
      if (req_en_i[i] && !req_rdy_o[i] && (perf_stall_q[i] != '1)) begin
        perf_stall_d[i] = perf_stall_q[i] + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge ui_clk_i) begin
    if (ui_clk_sync_rst_i) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_grant_o = perf_grant_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single DRAM request/response channel of the MIG-based DRAM controller between `NUM_REQ` cache-side requesters (requester 0 = instruction cache, 1 = data cache by default). Requests are arbitrated round-robin into a one-entry output register that drives the controller's request side. Read responses, which return in issue order, are steered back to the issuing requester by an in-order tag FIFO. Runs entirely in the controller's `ui_clk` domain.

## Interface

- `NUM_REQ`, 2, number of requesters (≥2)
- `TAG_DEPTH`, 8, max outstanding reads (power of two)

- `ui_clk` in 1: single clock, the DRAM controller's UI clock
- `ui_clk_sync_rst` in 1: reset, synchronous, active-high
- `req_en[NUM_REQ]` in 1 each: requester i presents a request
- `req_rdy[NUM_REQ]` out 1 each: requester i granted this cycle; transfer = `req_en[i] && req_rdy[i]`
- `req_cmd[NUM_REQ]` in 1 each: 0 write, 1 read
- `req_addr[NUM_REQ]` in 27 each: DRAM app address
- `req_data[NUM_REQ]` in 128 each: write data (ignored for reads)
- `rsp_en[NUM_REQ]` out 1 each: read data valid for requester i
- `rsp_data` out 128: read data, broadcast to all requesters
- `dram_req_en` out 1: request valid toward controller
- `dram_req_rdy` in 1: controller accepts (its IDLE state)
- `dram_req_cmd` out 1, `dram_req_addr` out 27, `dram_req_data` out 128: registered request
- `dram_rsp_en` in 1, `dram_rsp_data` in 128: controller read return
- `err_rsp_unexp` out 1: sticky, response arrived with no outstanding read

## Operation

- Output register `obuf` {valid, cmd, addr, data}; `obuf` can load when `!valid || (dram_req_en && dram_req_rdy)`.
- Eligibility: requester i eligible if `req_en[i]` and (`req_cmd[i]==0` or `tag_count < TAG_DEPTH`). `tag_count` is the registered value; no same-cycle pop bypass.
- Round-robin: pointer `last` (reset `NUM_REQ-1`); search starts at `last+1` mod `NUM_REQ`; first eligible wins. Only if `obuf` can load does the winner get `req_rdy[i]=1` (one-hot, else all 0); then `last <= i`, `obuf` loads the request.
- Read accepted → push requester id into tag FIFO in the same cycle.
- `dram_rsp_en`: pop tag FIFO head h; `rsp_en[h]=1`, others 0; `rsp_data = dram_rsp_data` combinationally.
- `dram_rsp_en` with tag FIFO empty: no `rsp_en`, no pop, `err_rsp_unexp <= 1` until reset.
- Simultaneous push and pop: both occur, count unchanged; pointers wrap mod `TAG_DEPTH`.
- Ordering: downstream issue order equals grant order; no address hazard checking (caches must not have a write and read to the same line in flight from different requesters).
- Reset mid-operation: all state cleared; in-flight reads are lost; controller is reset by the same `ui_clk_sync_rst`.

## Timing

- Reset values: `req_rdy`=0, `dram_req_en`=0, `dram_req_cmd/addr/data`=0, `rsp_en`=0, `err_rsp_unexp`=0, `tag_count`=0, `last`=`NUM_REQ-1`.
- Request latency: accepted at edge N → `dram_req_en` high from cycle N+1; holds stable until `dram_req_rdy`.
- Throughput: one request per cycle when `dram_req_rdy` held high (load and drain same cycle).
- `req_rdy[i]` is combinational from `req_en`, `req_cmd`, `obuf` state, `dram_req_rdy`; requesters must not make `req_en` depend on `req_rdy`.
- Response path: zero cycles, purely combinational.

## Configuration

- `DRAM_ARB_PERF_EN` defined: per-requester 32-bit saturating counters `perf_grant[i]` (granted requests) and `perf_stall[i]` (cycles `req_en[i]` high without `req_rdy[i]`), exported as extra output ports, reset 0.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure

- `dram_arb_pkg`: `DRAM_ADDR_W=27`, `DRAM_DATA_W=128`, `CMD_WRITE=1'b0`, `CMD_READ=1'b1`, typedef `dram_req_t` {cmd, addr, data}.
- Sub-module `dram_arb_tag_fifo`: synchronous FIFO of `$clog2(NUM_REQ)`-bit ids, depth `TAG_DEPTH`, push/pop/count/empty/full.

## Test plan

- Reset: assert `ui_clk_sync_rst` 2 cycles → all outputs 0; first simultaneous request from 0 and 1 grants requester 0.
- Round-robin: both issue continuous writes, `dram_req_rdy`=1 → grants alternate 0,1,0,1; `dram_req_addr` follows 1 cycle later.
- Backpressure: `dram_req_rdy`=0 for 5 cycles with `obuf` valid → `dram_req_*` stable, all `req_rdy`=0; release → drains, next grant same cycle.
- Response steering: reads from 1, 0, 1 (addrs 0x10, 0x20, 0x30); return data A, B, C → `rsp_en` pulses on 1, 0, 1 with data A, B, C.
- Credit limit: 8 reads outstanding from requester 0 → 9th read stalled while requester 1 write still granted; one response → read granted next cycle.
- Unexpected response: `dram_rsp_en` with no reads outstanding → no `rsp_en`, `err_rsp_unexp`=1 sticky until reset.
